// File: rtl/animation_draw_car.sv
// Paints a 15x15 car sprite from ROM at a latched location, one pixel per clock.
// Define CAR_TRANSPARENT_EN to suppress plotting of TRANSPARENT_COLOUR pixels.
module animation_draw_car #(
    parameter int         SPRITE_W           = 15,
    parameter int         SPRITE_H           = 15,
    parameter int         ROM_LATENCY        = 2,
    parameter int         SCREEN_W           = 160,
    parameter int         SCREEN_H           = 120,
    parameter logic [8:0] TRANSPARENT_COLOUR = 9'h1FF
) (
    input  logic        iClock,
    input  logic        iResetn,
    input  logic        drawCar,
    input  logic [7:0]  RX,
    input  logic [6:0]  RY,
    input  logic [2:0]  Rdir,
    input  logic [8:0]  iSpriteQ,
    output logic [10:0] oSpriteAddr,
    output logic [7:0]  oX,
    output logic [6:0]  oY,
    output logic [8:0]  oColour,
    output logic        oPlot,
    output logic        drawCarDone,
    output logic        oBusy
);

    localparam int NPIX  = SPRITE_W * SPRITE_H;
    localparam int IDX_W = $clog2(NPIX);
    localparam int COL_W = $clog2(SPRITE_W);
    localparam int ROW_W = $clog2(SPRITE_H);
    localparam int DRN_W = $clog2(ROM_LATENCY + 1);

    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(NPIX - 1);
    localparam logic [ROW_W-1:0] ROW_LAST    = ROW_W'(SPRITE_H - 1);
    localparam logic [DRN_W-1:0] DRN_LAST    = DRN_W'(ROM_LATENCY - 1);
    localparam logic [10:0]      SPRITE_SIZE = 11'(NPIX);

`ifdef CAR_TRANSPARENT_EN
    localparam bit TRANS_EN = 1'b1;
`else
    localparam bit TRANS_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    state_t state, next_state;

    logic [7:0]       rx_l;
    logic [6:0]       ry_l;
    logic [2:0]       dir_l;
    logic [IDX_W-1:0] idx;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic [DRN_W-1:0] drain_cnt;

    logic [8:0] x_pipe [ROM_LATENCY];
    logic [7:0] y_pipe [ROM_LATENCY];
    logic       v_pipe [ROM_LATENCY];

    logic [8:0] x_sum, x_out;
    logic [7:0] y_sum, y_out;
    logic       v_out, on_screen, key_hit;

    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (drawCar) next_state = ISSUE;
            ISSUE:   if (idx == IDX_LAST) next_state = DRAIN;
            DRAIN:   if (drain_cnt == DRN_LAST) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Column-major walk: row runs down the column, then col steps right.
    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) begin
            rx_l      <= '0;
            ry_l      <= '0;
            dir_l     <= '0;
            idx       <= '0;
            col       <= '0;
            row       <= '0;
            drain_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (drawCar) begin
                        rx_l  <= RX;
                        ry_l  <= RY;
                        dir_l <= Rdir;
                        idx   <= '0;
                        col   <= '0;
                        row   <= '0;
                    end
                end
                ISSUE: begin
                    idx       <= idx + 1'b1;
                    drain_cnt <= '0;
                    if (row == ROW_LAST) begin
                        row <= '0;
                        col <= col + 1'b1;
                    end else begin
                        row <= row + 1'b1;
                    end
                end
                DRAIN:   drain_cnt <= drain_cnt + 1'b1;
                default: ;
            endcase
        end
    end

    assign x_sum = {1'b0, rx_l} + 9'(col);
    assign y_sum = {1'b0, ry_l} + 8'(row);

    // Coordinates and valid travel alongside the ROM read so they meet iSpriteQ.
    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) begin
            for (int i = 0; i < ROM_LATENCY; i++) begin
                x_pipe[i] <= '0;
                y_pipe[i] <= '0;
                v_pipe[i] <= 1'b0;
            end
        end else begin
            x_pipe[0] <= x_sum;
            y_pipe[0] <= y_sum;
            v_pipe[0] <= (state == ISSUE);
            for (int i = 1; i < ROM_LATENCY; i++) begin
                x_pipe[i] <= x_pipe[i-1];
                y_pipe[i] <= y_pipe[i-1];
                v_pipe[i] <= v_pipe[i-1];
            end
        end
    end

    assign x_out     = x_pipe[ROM_LATENCY-1];
    assign y_out     = y_pipe[ROM_LATENCY-1];
    assign v_out     = v_pipe[ROM_LATENCY-1];
    assign on_screen = (x_out < 9'(SCREEN_W)) && (y_out < 8'(SCREEN_H));
    assign key_hit   = TRANS_EN && (iSpriteQ == TRANSPARENT_COLOUR);

    assign oPlot       = v_out && on_screen && !key_hit;
    assign oColour     = v_out ? iSpriteQ : '0;
    assign oX          = x_out[7:0];
    assign oY          = y_out[6:0];
    assign oSpriteAddr = (state == ISSUE) ? (11'(dir_l) * SPRITE_SIZE + 11'(idx)) : '0;
    assign drawCarDone = (state == DONE);
    assign oBusy       = (state != IDLE);

endmodule

// File: tb/tb_animation_draw_car.sv
// Self-checking bench for animation_draw_car: directed and randomized draws vs a behavioural model.
module tb_animation_draw_car;

    logic        clk = 1'b0;
    logic        iResetn;
    logic        drawCar;
    logic [7:0]  RX;
    logic [6:0]  RY;
    logic [2:0]  Rdir;
    logic [8:0]  iSpriteQ = '0;
    logic [10:0] oSpriteAddr;
    logic [7:0]  oX;
    logic [6:0]  oY;
    logic [8:0]  oColour;
    logic        oPlot;
    logic        drawCarDone;
    logic        oBusy;

    logic [10:0] rom_a = '0;
    int          rom_mode = 0;
    int          rom_seed = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    animation_draw_car dut (
        .iClock      (clk),
        .iResetn     (iResetn),
        .drawCar     (drawCar),
        .RX          (RX),
        .RY          (RY),
        .Rdir        (Rdir),
        .iSpriteQ    (iSpriteQ),
        .oSpriteAddr (oSpriteAddr),
        .oX          (oX),
        .oY          (oY),
        .oColour     (oColour),
        .oPlot       (oPlot),
        .drawCarDone (drawCarDone),
        .oBusy       (oBusy)
    );

    // Sprite contents as a function of the ROM address.
    function automatic logic [8:0] rom_f(input int a);
        int k;
        k = a % 225;
        case (rom_mode)
            0:       return 9'(k);
            1:       return 9'(a * 131 + rom_seed);
            2:       return (k % 2 == 0) ? 9'h1FF : 9'(k);
            default: return 9'h000;
        endcase
    endfunction

    // Two-clock ROM: registered address then registered data.
    always @(posedge clk) begin
        rom_a    <= oSpriteAddr;
        iSpriteQ <= rom_f(int'(rom_a));
    end

    function automatic bit model_plot(input int rx, input int ry, input int dir, input int k);
        int  x, y;
        bit  key;
        x = rx + k / 15;
        y = ry + k % 15;
`ifdef CAR_TRANSPARENT_EN
        key = (rom_f(dir * 225 + k) == 9'h1FF);
`else
        key = 1'b0;
`endif
        return (x < 160) && (y < 120) && !key;
    endfunction

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, " plot"},  32'(oPlot), 0);
        check_output({tag, " x"},     32'(oX), 0);
        check_output({tag, " y"},     32'(oY), 0);
        check_output({tag, " colour"},32'(oColour), 0);
        check_output({tag, " addr"},  32'(oSpriteAddr), 0);
        check_output({tag, " done"},  32'(drawCarDone), 0);
        check_output({tag, " busy"},  32'(oBusy), 0);
    endtask

    // One draw; cycle c is the c-th clock period after the start edge.
    task automatic apply_stimulus(input logic [7:0] rx, input logic [6:0] ry, input logic [2:0] dir,
                                  input int mode, input int repulse_at, input int reset_at, input bit hold);
        int rxi, ryi, diri, k, plots, exp_plots;
        bit exp_plot;
        rxi = int'(rx);
        ryi = int'(ry);
        diri = int'(dir);
        plots = 0;
        exp_plots = 0;
        rom_mode = mode;
        for (int j = 0; j < 225; j++) if (model_plot(rxi, ryi, diri, j)) exp_plots++;
        $display("[TB] draw rx=%0d ry=%0d dir=%0d mode=%0d expecting %0d plots", rxi, ryi, diri, mode, exp_plots);

        @(negedge clk);
        RX = rx;
        RY = ry;
        Rdir = dir;
        drawCar = 1'b1;
        @(negedge clk);
        drawCar = hold;
        for (int c = 1; c <= 230; c++) begin
            if (c <= 225)
                check_output($sformatf("addr@%0d", c), 32'(oSpriteAddr), diri * 225 + c - 1);
            if (hold && c == 230)
                check_output("restart addr", 32'(oSpriteAddr), diri * 225);
            k = c - 3;
            exp_plot = (k >= 0) && (k <= 224) && model_plot(rxi, ryi, diri, k);
            check_output($sformatf("plot@%0d", c), 32'(oPlot), 32'(exp_plot));
            if (exp_plot) begin
                check_output($sformatf("x@%0d", c), 32'(oX), rxi + k / 15);
                check_output($sformatf("y@%0d", c), 32'(oY), ryi + k % 15);
                check_output($sformatf("colour@%0d", c), 32'(oColour), 32'(rom_f(diri * 225 + k)));
            end
            if (oPlot === 1'b1) plots++;
            check_output($sformatf("done@%0d", c), 32'(drawCarDone), 32'(c == 228));
            check_output($sformatf("busy@%0d", c), 32'(oBusy), 32'((c <= 228) || (hold && c == 230)));

            if (c == reset_at) begin
                iResetn = 1'b0;
                drawCar = 1'b0;
                #1;
                check_all_zero("midreset");
                @(negedge clk);
                iResetn = 1'b1;
                return;
            end
            if (!hold) begin
                RX = 8'($urandom);
                RY = 7'($urandom);
                Rdir = 3'($urandom);
                drawCar = (c == repulse_at);
            end
            @(negedge clk);
        end
        check_output("plot count", 32'(plots), 32'(exp_plots));
        drawCar = 1'b0;
        if (hold) begin
            iResetn = 1'b0;
            @(negedge clk);
            iResetn = 1'b1;
        end
    endtask

    initial begin
        rom_seed = int'($urandom_range(0, 511));
        iResetn = 1'b0;
        drawCar = 1'b1;
        RX = 8'd0;
        RY = 7'd0;
        Rdir = 3'd0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        drawCar = 1'b0;
        iResetn = 1'b1;
        @(negedge clk);
        check_output("idle busy", 32'(oBusy), 0);

        apply_stimulus(8'd10, 7'd20, 3'd0, 0, 0, 0, 1'b0);
        apply_stimulus(8'd10, 7'd20, 3'd5, 0, 0, 0, 1'b0);
        apply_stimulus(8'd150, 7'd110, 3'd3, 1, 0, 0, 1'b0);
        apply_stimulus(8'd40, 7'd30, 3'd2, 1, 50, 0, 1'b0);
        apply_stimulus(8'd60, 7'd50, 3'd6, 1, 0, 100, 1'b0);
        apply_stimulus(8'd10, 7'd20, 3'd7, 0, 0, 0, 1'b0);
        apply_stimulus(8'd5, 7'd5, 3'd1, 2, 0, 0, 1'b0);
        apply_stimulus(8'd100, 7'd100, 3'd4, 0, 0, 0, 1'b1);
        for (int r = 0; r < 4; r++)
            apply_stimulus(8'($urandom), 7'($urandom), 3'($urandom), 1, 0, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
